// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU codes, multicycle state encodings,
// mux-select constants and the packed control word used by the controller.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_SUB  = 6'b100010;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH   = 4'd0;
   localparam state_t S_DECODE  = 4'd1;
   localparam state_t S_MEMADR  = 4'd2;
   localparam state_t S_MEMRD   = 4'd3;
   localparam state_t S_MEMWB   = 4'd4;
   localparam state_t S_MEMWR   = 4'd5;
   localparam state_t S_EXECUTE = 4'd6;
   localparam state_t S_ALUWB   = 4'd7;
   localparam state_t S_BRANCH  = 4'd8;
   localparam state_t S_ADDIEX  = 4'd9;
   localparam state_t S_ADDIWB  = 4'd10;
   localparam state_t S_JUMP    = 4'd11;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       ir_write;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [5:0] alucontrol;
   } ctrl_t;

   function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Bundle between the multicycle controller (master) and the datapath (slave):
// instruction/zero flag in, per-cycle enables and mux selects out.
interface mc_controller_if #(parameter int ALUC_W = 6) ();

   logic [31:0]       instr;
   logic              zero;
   logic              pc_en;
   logic              iord;
   logic              ir_write;
   logic              mem_write;
   logic              reg_dst;
   logic              mem_to_reg;
   logic              reg_write;
   logic              alu_src_a;
   logic [1:0]        alu_src_b;
   logic [1:0]        pc_src;
   logic [ALUC_W-1:0] alucontrol;
   logic [3:0]        state;

   modport master (
      input  instr, zero,
      output pc_en, iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, pc_src, alucontrol, state
   );

   modport slave (
      output instr, zero,
      input  pc_en, iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, pc_src, alucontrol, state
   );

endinterface

// File: rtl/mc_outdec.sv
// Combinational control-word decoder: Moore outputs per state, plus the
// zero-dependent PC enable and the funct-driven ALU code in EXECUTE.
module mc_outdec
   import mips_pkg::*;
(
   input  state_t      state_i,
   input  logic [31:0] instr_i,
   input  logic        zero_i,
   output ctrl_t       ctrl_o
);

   logic pcWrite;
   logic branchEq;
   logic branchNe;

   always_comb begin
      ctrl_o            = '0;
      ctrl_o.alucontrol = ALU_ADD;
      pcWrite           = 1'b0;
      branchEq          = 1'b0;
      branchNe          = 1'b0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.ir_write  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            pcWrite          = 1'b1;
         end
         S_DECODE:  ctrl_o.alu_src_b = SRCB_IMMSH;
         S_MEMADR, S_ADDIEX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD:   ctrl_o.iord = 1'b1;
         S_MEMWB: begin
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord      = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alucontrol = instr_i[5:0];
         end
         S_ALUWB: begin
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alucontrol = ALU_SUB;
            ctrl_o.pc_src     = PCSRC_ALUOUT;
            branchEq          = (opcodeOf(instr_i) == OP_BEQ);
            branchNe          = (opcodeOf(instr_i) == OP_BNE);
         end
         S_ADDIWB:  ctrl_o.reg_write = 1'b1;
         S_JUMP: begin
            ctrl_o.pc_src = PCSRC_JUMP;
            pcWrite       = 1'b1;
         end
         // Unused encodings drive a fully quiet control word, ALU code included.
         default:   ctrl_o.alucontrol = '0;
      endcase
      ctrl_o.pc_en = pcWrite | (branchEq & zero_i) | (branchNe & ~zero_i);
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: holds the state register and next-state logic,
// and delegates the per-state control word to mc_outdec.
module mc_controller
   import mips_pkg::*;
#(
   parameter int ALUC_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   mc_controller_if.master bus
);

   state_t stateQ;
   state_t stateD;
   ctrl_t  ctrl;
   logic [5:0] op;

   assign op = opcodeOf(bus.instr);

   always_ff @(posedge clk) begin
      if (rst) stateQ <= S_FETCH;
      else     stateQ <= stateD;
   end

   // Unknown opcodes fall back to FETCH straight from DECODE, acting as a NOP.
   always_comb begin
      stateD = S_FETCH;
      case (stateQ)
         S_FETCH:  stateD = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:   stateD = S_MEMADR;
               OP_RTYPE:       stateD = S_EXECUTE;
               OP_BEQ, OP_BNE: stateD = S_BRANCH;
               OP_ADDI:        stateD = S_ADDIEX;
               OP_J:           stateD = S_JUMP;
               default:        stateD = S_FETCH;
            endcase
         end
         S_MEMADR:  stateD = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   stateD = S_MEMWB;
         S_EXECUTE: stateD = S_ALUWB;
         S_ADDIEX:  stateD = S_ADDIWB;
         default:   stateD = S_FETCH;
      endcase
   end

   mc_outdec uOutdec (
      .state_i (stateQ),
      .instr_i (bus.instr),
      .zero_i  (bus.zero),
      .ctrl_o  (ctrl)
   );

   assign bus.pc_en      = ctrl.pc_en;
   assign bus.iord       = ctrl.iord;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.pc_src     = ctrl.pc_src;
   assign bus.alucontrol = ctrl.alucontrol[ALUC_W-1:0];
   assign bus.state      = stateQ;

endmodule
